nmi2apb_bridge: RTL and testbench
=================================

# nmi2apb_bridge

Protocol bridge between the core-side native memory interface (NMI: valid/addr/wdata/wstrb/rdata/ready) and an APB4 peripheral segment. It sits directly downstream of an NMI master (CPU or crossbar port): it accepts one NMI request, runs exactly one APB4 SETUP/ACCESS transfer, and returns a one-cycle NMI `ready` pulse carrying read data. It supports one outstanding transfer and never buffers a second request.

## Interface
- `TIMEOUT_CYCLES`, default 255: ACCESS-phase cycles without `pready` before abort. Used only with `NMI2APB_TIMEOUT_EN`. Legal range 1..65535.
- `ERR_RDATA`, default 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- `clk_i` in 1: single clock. All logic is on the rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `nmi_valid_i` in 1: request valid. The master holds it, with stable addr, wdata and wstrb, until it sees `ready`.
- `nmi_addr_i` in 32: byte address, passed unmodified.
- `nmi_wdata_i` in 32: write data.
- `nmi_wstrb_i` in 4: byte strobes. 0 means read; nonzero means write.
- `nmi_rdata_o` out 32: read data. Valid only while `nmi_ready_o`=1.
- `nmi_ready_o` out 1: completion pulse, exactly one cycle wide, registered.
- `apb_paddr_o` out 32, `apb_pwdata_o` out 32, `apb_pstrb_o` out 4, `apb_pwrite_o` out 1, `apb_pprot_o` out 3 (always 3'b000), `apb_psel_o` out 1, `apb_penable_o` out 1: APB4 requester outputs, all registered.
- `apb_prdata_i` in 32, `apb_pready_i` in 1, `apb_pslverr_i` in 1: APB4 completer response.
- `err_o` out 1: one-cycle pulse, coincident with `nmi_ready_o`, when the transfer ended with `pslverr`=1 or with a timeout.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If `nmi_valid_i`=1, register addr, wdata and wstrb.
  - Set `pwrite` = |wstrb and `pstrb` = wstrb. Reads drive `pstrb`=0 and `pwdata`=0.
  - Go to SETUP.
- SETUP: `psel`=1, `penable`=0. Unconditionally go to ACCESS.
- ACCESS: `psel`=1, `penable`=1.
  - When `pready`=1: capture `prdata` (reads only; writes return 0) and `pslverr`, then go to RESP.
  - Otherwise stay in ACCESS. APB address and control stay stable throughout.
- RESP: `psel`=`penable`=0, `nmi_ready_o`=1, `nmi_rdata_o` = captured data, `err_o` = captured error. Go to IDLE.
- `nmi_valid_i` is ignored in SETUP, ACCESS and RESP. This prevents re-issue during the `ready` cycle.
- Inputs are sampled only in IDLE, so a master that changes request fields mid-transfer (a protocol violation) does not affect the APB transfer.
- `pslverr` does not suppress `nmi_ready_o`. For a read, the `prdata` returned by the completer is still forwarded.

## Timing
- Reset: state=IDLE. Every output is 0: `nmi_ready_o`, `nmi_rdata_o`, `err_o`, `psel`, `penable`, `paddr`, `pwdata`, `pstrb`, `pwrite`, `pprot`. The timeout counter is 0.
- Reset asserted mid-transfer: at the next edge, `psel`/`penable` drop to 0 and the transfer is abandoned with no `nmi_ready_o`.
- Zero-wait completer: valid is sampled in cycle 0, SETUP is cycle 1, ACCESS is cycle 2 (`pready`=1), `nmi_ready_o`=1 in cycle 3. Latency is 3 cycles plus N APB wait states.
- Back-to-back: IDLE is reached in cycle 4. If `valid` is still high with a new request, SETUP follows in cycle 5. Throughput is 1 transfer per 5 cycles.
- `nmi_ready_o` is never high in two consecutive cycles.

## Configuration
- Macro `NMI2APB_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with `pready`=0.
  - When the count reaches `TIMEOUT_CYCLES` with `pready` still 0, the bridge goes to RESP with `psel`/`penable` deasserted, `nmi_rdata_o`=`ERR_RDATA` for reads (0 for writes), and `err_o`=1.
  - `pready`=1 in the same cycle as the limit wins: normal completion.
- Undefined: no counter is built, ACCESS waits indefinitely, and `TIMEOUT_CYCLES` and `ERR_RDATA` are unused.

## Test plan
- Read, zero-wait: addr 0x1000_0004, wstrb 0, `prdata`=0xA5A5_1234 -> `psel` in cycle 1, `penable` in cycle 2, `pwrite`=0, `nmi_ready_o` for exactly one cycle in cycle 3 with rdata 0xA5A5_1234 and `err_o`=0.
- Write, 3 wait states: wstrb 4'b0110, wdata 0x1122_3344 -> `pwrite`=1, `pstrb`=0110, APB signals stable for 4 ACCESS cycles, `nmi_ready_o` in cycle 6.
- Back-to-back: `valid` held high across `ready` with a new read -> second SETUP in cycle 5, and the first request is not re-issued.
- `pslverr`=1 on write -> `nmi_ready_o` and `err_o` both high for one cycle.
- Reset during ACCESS (`pready`=0) -> all outputs 0 next cycle, no `ready`; then a new read completes normally.
- With `NMI2APB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `pready` stuck 0 on a read -> `psel` drops and `nmi_rdata_o`=0xDEAD_BEEF with `err_o`=1. Without the macro -> the bridge stays in ACCESS for 1000 cycles and no `ready` appears.

Source files
------------

// File: rtl/nmi2apb_bridge.sv
// nmi2apb_bridge: NMI-to-APB4 bridge, one outstanding transfer; define NMI2APB_TIMEOUT_EN to abort stalled ACCESS phases
module nmi2apb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        nmi_valid_i,
    input  logic [31:0] nmi_addr_i,
    input  logic [31:0] nmi_wdata_i,
    input  logic [3:0]  nmi_wstrb_i,
    output logic [31:0] nmi_rdata_o,
    output logic        nmi_ready_o,
    output logic [31:0] apb_paddr_o,
    output logic [31:0] apb_pwdata_o,
    output logic [3:0]  apb_pstrb_o,
    output logic        apb_pwrite_o,
    output logic [2:0]  apb_pprot_o,
    output logic        apb_psel_o,
    output logic        apb_penable_o,
    input  logic [31:0] apb_prdata_i,
    input  logic        apb_pready_i,
    input  logic        apb_pslverr_i,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state, next;
    logic   timeout;
    logic   done;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("nmi2apb_bridge: TIMEOUT_CYCLES out of range");
    end

`ifdef NMI2APB_TIMEOUT_EN
    logic [15:0] cnt;
    // count stalled ACCESS cycles, restarting whenever a new ACCESS phase begins
    always_ff @(posedge clk_i) begin
        if (rst_i || state == SETUP)
            cnt <= '0;
        else if (state == ACCESS && !apb_pready_i)
            cnt <= cnt + 16'd1;
    end
    assign timeout = !apb_pready_i && (32'(cnt) + 32'd1 >= TIMEOUT_CYCLES);
`else
    assign timeout = 1'b0;
`endif

    assign done        = state == ACCESS && (apb_pready_i || timeout);
    assign apb_pprot_o = 3'b000;

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= next;
    end

    // next-state logic: one APB transfer per accepted request, valid ignored outside IDLE
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = nmi_valid_i ? SETUP : IDLE;
            SETUP:   next = ACCESS;
            ACCESS:  next = done ? RESP : ACCESS;
            default: next = IDLE;
        endcase
    end

    // registered outputs: APB phase strobes follow the next state, request fields latch only in IDLE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            apb_psel_o    <= 1'b0;
            apb_penable_o <= 1'b0;
            nmi_ready_o   <= 1'b0;
            apb_paddr_o   <= '0;
            apb_pwdata_o  <= '0;
            apb_pstrb_o   <= '0;
            apb_pwrite_o  <= 1'b0;
            nmi_rdata_o   <= '0;
            err_o         <= 1'b0;
        end else begin
            apb_psel_o    <= next == SETUP || next == ACCESS;
            apb_penable_o <= next == ACCESS;
            nmi_ready_o   <= next == RESP;
            if (state == IDLE && nmi_valid_i) begin
                apb_paddr_o  <= nmi_addr_i;
                apb_pwrite_o <= |nmi_wstrb_i;
                apb_pstrb_o  <= nmi_wstrb_i;
                apb_pwdata_o <= |nmi_wstrb_i ? nmi_wdata_i : '0;
            end
            if (done) begin
                nmi_rdata_o <= apb_pwrite_o ? '0 : apb_pready_i ? apb_prdata_i : ERR_RDATA;
                err_o       <= apb_pready_i ? apb_pslverr_i : 1'b1;
            end else if (state == RESP) begin
                nmi_rdata_o <= '0;
                err_o       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_nmi2apb_bridge.sv
// tb_nmi2apb_bridge: randomized transaction bench with a cycle-timeline model of the bridge
module tb_nmi2apb_bridge;
    localparam int TO = 4;
    localparam int N  = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nmi_valid = 1'b0;
    logic [31:0] nmi_addr = '0, nmi_wdata = '0;
    logic [3:0]  nmi_wstrb = '0;
    logic [31:0] nmi_rdata;
    logic        nmi_ready;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic        pwrite, psel, penable, err;
    logic [2:0]  pprot;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0, pslverr = 1'b0;

    nmi2apb_bridge #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk_i(clk), .rst_i(rst),
        .nmi_valid_i(nmi_valid), .nmi_addr_i(nmi_addr), .nmi_wdata_i(nmi_wdata), .nmi_wstrb_i(nmi_wstrb),
        .nmi_rdata_o(nmi_rdata), .nmi_ready_o(nmi_ready),
        .apb_paddr_o(paddr), .apb_pwdata_o(pwdata), .apb_pstrb_o(pstrb), .apb_pwrite_o(pwrite),
        .apb_pprot_o(pprot), .apb_psel_o(psel), .apb_penable_o(penable),
        .apb_prdata_i(prdata), .apb_pready_i(pready), .apb_pslverr_i(pslverr),
        .err_o(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    bit          exp_zero[N], exp_psel[N], exp_pen[N], exp_ready[N], exp_err[N], exp_pwrite[N];
    logic [31:0] exp_paddr[N], exp_pwdata[N], exp_rdata[N];
    logic [3:0]  exp_pstrb[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        nmi_addr  = $urandom;
        nmi_wdata = $urandom;
        nmi_wstrb = 4'($urandom);
    endtask

    // compare every cycle against the timeline model
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < N) begin
            if (exp_zero[cyc]) begin
                chk("reset_ctrl", {psel, penable, nmi_ready, err, pwrite, pprot, pstrb}, 64'd0);
                chk("reset_addr", paddr, 64'd0);
                chk("reset_wdata", pwdata, 64'd0);
                chk("reset_rdata", nmi_rdata, 64'd0);
            end else begin
                chk("ctrl", {psel, penable, nmi_ready, err},
                    {exp_psel[cyc], exp_pen[cyc], exp_ready[cyc], exp_err[cyc]});
                chk("pprot", pprot, 64'd0);
                if (exp_psel[cyc]) begin
                    chk("paddr", paddr, exp_paddr[cyc]);
                    chk("pwdata", pwdata, exp_pwdata[cyc]);
                    chk("pstrb_pwrite", {pstrb, pwrite}, {exp_pstrb[cyc], exp_pwrite[cyc]});
                end
                if (exp_ready[cyc])
                    chk("rdata", nmi_rdata, exp_rdata[cyc]);
            end
        end
    end

    // one NMI request: w APB wait states; to = completer never answers (timeout build only)
    task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int w,
                          input bit slv, input bit to, input bit keep, input logic [31:0] rd);
        int k = cyc;
        bit wr = |s;
        for (int c = k + 1; c <= k + 2 + w; c++) begin
            exp_psel[c]   = 1'b1;
            exp_pen[c]    = c >= k + 2;
            exp_paddr[c]  = a;
            exp_pwdata[c] = wr ? d : 32'd0;
            exp_pstrb[c]  = s;
            exp_pwrite[c] = wr;
        end
        exp_ready[k + 3 + w] = 1'b1;
        exp_err[k + 3 + w]   = slv || to;
        exp_rdata[k + 3 + w] = wr ? 32'd0 : to ? 32'hDEAD_BEEF : rd;
        nmi_valid = 1'b1;
        nmi_addr  = a;
        nmi_wdata = d;
        nmi_wstrb = s;
        tick();
        scramble();
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
        for (int c = k + 2; c <= k + 2 + w; c++) begin
            tick();
            scramble();
            pready  = (c == k + 2 + w) && !to;
            prdata  = (c == k + 2 + w) ? rd : $urandom;
            pslverr = (c == k + 2 + w) ? slv : 1'($urandom);
        end
        tick();
        pready    = 1'b0;
        nmi_valid = keep;
        tick();
        nmi_valid = 1'b0;
    endtask

    // request stalled for n ACCESS cycles, then reset asserted during the last of them
    task automatic do_abort(input int n);
        int k = cyc;
        logic [31:0] a = $urandom;
        for (int c = k + 1; c <= k + 1 + n; c++) begin
            exp_psel[c]   = 1'b1;
            exp_pen[c]    = c >= k + 2;
            exp_paddr[c]  = a;
            exp_pwdata[c] = 32'd0;
            exp_pstrb[c]  = 4'd0;
            exp_pwrite[c] = 1'b0;
        end
        exp_zero[k + 2 + n] = 1'b1;
        nmi_valid = 1'b1;
        nmi_addr  = a;
        nmi_wstrb = 4'd0;
        tick();
        pready = 1'b0;
        for (int c = k + 2; c <= k + 1 + n; c++) begin
            tick();
            if (c == k + 1 + n) rst = 1'b1;
        end
        tick();
        rst       = 1'b0;
        nmi_valid = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit keep;
        bit prev_keep;
        int w;
        bit to;
        for (int c = 1; c <= 3; c++) exp_zero[c] = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        k = cyc;
        do_txn(32'h1000_0004, $urandom, 4'b0000, 0, 1'b0, 1'b0, 1'b0, 32'hA5A5_1234);
        chk("pin_read_psel_c1", {exp_psel[k + 1], exp_pen[k + 1]}, 64'b10);
        chk("pin_read_pen_c2", {exp_psel[k + 2], exp_pen[k + 2], exp_pwrite[k + 2]}, 64'b110);
        chk("pin_read_ready_c3", {exp_ready[k + 2], exp_ready[k + 3], exp_ready[k + 4]}, 64'b010);
        chk("pin_read_rdata", exp_rdata[k + 3], 64'hA5A5_1234);

        k = cyc;
        do_txn($urandom, 32'h1122_3344, 4'b0110, 3, 1'b0, 1'b0, 1'b0, $urandom);
        chk("pin_write_ready_c6", {exp_ready[k + 5], exp_ready[k + 6]}, 64'b01);
        chk("pin_write_access", {exp_pen[k + 2], exp_pen[k + 5], exp_pstrb[k + 5], exp_pwrite[k + 5]}, 64'b1101101);
        chk("pin_write_data", exp_pwdata[k + 4], 64'h1122_3344);

        k = cyc;
        do_txn(32'h2000_0000, $urandom, 4'b0000, 0, 1'b0, 1'b0, 1'b1, $urandom);
        do_txn(32'h2000_0008, $urandom, 4'b0000, 0, 1'b0, 1'b0, 1'b0, $urandom);
        chk("pin_b2b_setup", {exp_psel[k + 4], exp_psel[k + 5], exp_pen[k + 5]}, 64'b010);

        k = cyc;
        do_txn($urandom, $urandom, 4'b1111, 1, 1'b1, 1'b0, 1'b0, $urandom);
        chk("pin_slverr", {exp_ready[k + 4], exp_err[k + 4], exp_rdata[k + 4]}, {2'b11, 32'd0});

        do_abort(2);
        do_txn($urandom, $urandom, 4'b0000, 1, 1'b0, 1'b0, 1'b0, $urandom);

`ifdef NMI2APB_TIMEOUT_EN
        k = cyc;
        do_txn($urandom, $urandom, 4'b0000, TO - 1, 1'b0, 1'b1, 1'b0, $urandom);
        chk("pin_timeout", {exp_psel[k + 2 + TO], exp_ready[k + 2 + TO], exp_err[k + 2 + TO]}, 64'b011);
        chk("pin_timeout_rdata", exp_rdata[k + 2 + TO], 64'hDEAD_BEEF);
        do_txn($urandom, $urandom, 4'b0000, TO - 1, 1'b0, 1'b0, 1'b0, 32'h0BAD_F00D);
`else
        do_abort(1000);
`endif

        prev_keep = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!prev_keep) repeat ($urandom_range(0, 2)) tick();
            keep = (i != 39) && ($urandom_range(0, 2) == 0);
`ifdef NMI2APB_TIMEOUT_EN
            to = $urandom_range(0, 3) == 0;
            w  = to ? TO - 1 : int'($urandom_range(0, TO - 1));
`else
            to = 1'b0;
            w  = int'($urandom_range(0, 6));
`endif
            do_txn($urandom, $urandom, ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom),
                   w, 1'($urandom), to, keep, $urandom);
            prev_keep = keep;
        end
        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
